// File: rtl/sram_image_writer.sv
// sram_image_writer: packs a 784-byte pixel stream into 392 little-endian
// 16-bit words and writes them into one of four image slots of an async SRAM.
// Each word uses a SETUP / 2-cycle WRITE / HOLD strobe sequence with a stable
// address and data bus. All outputs are registered.
module sram_image_writer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [1:0]  slot,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORDS  = 392;
  localparam int unsigned IDX_W  = 9;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned WADR_W = 16;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS - 1);
  localparam logic [WADR_W-1:0] SLOT_WORDS = WADR_W'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       slot_q;
  logic [IDX_W-1:0] word_idx;
  logic [7:0]       lo_byte;
  logic             wr_cnt;
  logic [WADR_W-1:0] word_addr;

  // Word address of the word currently being assembled: slot base plus index.
  assign word_addr = WADR_W'(slot_q) * SLOT_WORDS + WADR_W'(word_idx);

  // Writer FSM with registered handshake, SRAM strobes and bus drive.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      slot_q   <= 2'd0;
      word_idx <= '0;
      lo_byte  <= 8'd0;
      wr_cnt   <= 1'b0;
      in_ready <= 1'b0;
      ADDR     <= '0;
      Data_out <= 16'd0;
      CE       <= 1'b1;
      UB       <= 1'b1;
      LB       <= 1'b1;
      OE       <= 1'b1;
      WE       <= 1'b1;
      Data_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      OE   <= 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            slot_q   <= slot;
            word_idx <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LO;
          end
        end
        S_LO: begin
          if (in_valid) begin
            lo_byte <= in_data;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (in_valid) begin
            // Address and data are launched together and held until HOLD ends.
            Data_out <= {in_data, lo_byte};
            ADDR     <= ADDR_W'(word_addr);
            in_ready <= 1'b0;
            CE       <= 1'b0;
            UB       <= 1'b0;
            LB       <= 1'b0;
            Data_oe  <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          WE     <= 1'b0;
          wr_cnt <= 1'b0;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_cnt) begin
            WE    <= 1'b1;
            state <= S_HOLD;
          end else begin
            wr_cnt <= 1'b1;
          end
        end
        S_HOLD: begin
          CE      <= 1'b1;
          UB      <= 1'b1;
          LB      <= 1'b1;
          Data_oe <= 1'b0;
          if (word_idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            in_ready <= 1'b1;
            state    <= S_LO;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          CE       <= 1'b1;
          UB       <= 1'b1;
          LB       <= 1'b1;
          WE       <= 1'b1;
          Data_oe  <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_image_writer.md
SRAM_IMAGE_WRITER -- requirements
Module: sram_image_writer

Interface
REQ-001: CLK  input  1  system clock; all state changes on the rising edge.
REQ-002: RESET  input  1  reset, asynchronous and active-high; one clock, CLK.
REQ-003: start  input  1  one-cycle request to load one image; sampled only in IDLE.
REQ-004: slot  input  2  image slot index; latched when start is accepted.
REQ-005: in_data  input  8  pixel byte from the upstream byte source.
REQ-006: in_valid  input  1  in_data valid.
REQ-007: in_ready  output  1  writer accepts the byte this cycle; a byte transfers when in_valid and in_ready are both 1.
REQ-008: ADDR  output  20  SRAM word address; equals {4'b0, slot*392 + word_idx}.
REQ-009: CE, UB, LB, OE, WE  output  1 each  SRAM controls, all active-low.
REQ-010: Data_out  output  16  SRAM write data.
REQ-011: Data_oe  output  1  tri-state enable for Data_out; 1 = drive the SRAM data bus.
REQ-012: busy  output  1  high from start acceptance through the DONE state; the top level uses it to grant the SRAM bus.
REQ-013: done  output  1  one-cycle pulse after the last word of an image is written.

Function
REQ-014: Image size SHALL be 392 16-bit words (784 bytes); word_idx SHALL run from 0 to 391; base address SHALL be slot*392 computed in 16 bits, so slot 3 spans addresses 1176 to 1567.
REQ-015: States SHALL be IDLE, LO, HI, SETUP, WRITE, HOLD and DONE.
REQ-016: IDLE: when start=1, latch slot, clear word_idx to 0 and go to LO.
REQ-017: LO: in_ready=1; on a transfer, latch in_data as the low byte and go to HI.
REQ-018: HI: in_ready=1; on a transfer, load Data_out={in_data, low byte} and go to SETUP.
REQ-019: Packing SHALL be little-endian: the first byte goes to bits [7:0] and the second to bits [15:8].
REQ-020: SETUP: lasts 1 cycle; CE=0, UB=0, LB=0, OE=1, WE=1, Data_oe=1, ADDR valid.
REQ-021: WRITE: lasts exactly 2 cycles (internal counter); as SETUP except WE=0.
REQ-022: HOLD: lasts 1 cycle; as SETUP with WE=1; ADDR and Data_out SHALL remain stable.
REQ-023: HOLD exit: if word_idx=391 go to DONE; otherwise increment word_idx and go to LO.
REQ-024: ADDR and Data_out SHALL NOT change during SETUP, WRITE or HOLD.
REQ-025: DONE: done=1 for 1 cycle, busy=1, then go to IDLE.
REQ-026: In IDLE, LO, HI and DONE: CE=1, UB=1, LB=1, OE=1, WE=1, Data_oe=0.
REQ-027: OE SHALL never be 0; the writer never reads.
REQ-028: in_ready SHALL be 0 in every state except LO and HI.
REQ-029: A byte presented while in_ready=0 SHALL NOT be consumed.
REQ-030: A start asserted while not in IDLE SHALL be ignored and SHALL NOT re-latch slot.
REQ-031: start and in_valid asserted in the same IDLE cycle: only start acts; the byte is not consumed.
REQ-032: Upstream stalls (in_valid=0) in LO or HI SHALL hold the state indefinitely with no SRAM activity.
REQ-033: Latency with in_valid held at 1: 6 cycles per word; done SHALL assert 2353 cycles after the start-accept cycle.
REQ-034: WE SHALL never be 0 while Data_oe=0.
REQ-035: WE SHALL never fall in the same cycle that ADDR changes.

Reset
REQ-036: RESET=1 SHALL asynchronously force state to IDLE, word_idx to 0 and slot to 0.
REQ-037: RESET=1 SHALL also force ADDR to 0, Data_out to 0, CE, UB, LB, OE and WE to 1, and Data_oe, in_ready, busy and done to 0.
REQ-038: RESET asserted mid-write, including during WRITE, SHALL release WE and Data_oe immediately, without waiting for a clock edge.
REQ-039: After a mid-write reset, no partial image state SHALL persist; the next start begins at word 0.

Verification
REQ-040: Reset, then start with slot=0, stream bytes 0x01,0x02,... continuously -> first write at ADDR=0 with Data_out=0x0201; done 2353 cycles after start; 392 WE pulses, each 2 cycles low.
REQ-041: slot=3, stream 784 bytes -> writes cover ADDR 1176 to 1567 exactly once each; SRAM model contents match the packed stream.
REQ-042: Random in_valid gaps of 0 to 5 cycles -> no lost or duplicated bytes; while waiting in LO or HI, WE=1 and Data_oe=0 throughout.
REQ-043: Assert start again at word 100 with slot=2 -> ignored; the image completes into the original slot's range.
REQ-044: Assert RESET in the second WRITE cycle of word 50 -> WE=1, Data_oe=0 and busy=0 the same cycle; a fresh start with slot=1 writes the first word to ADDR 392.
REQ-045: start and in_valid high in the same IDLE cycle -> that byte is not consumed; the first packed byte is the one accepted in LO.
